// File: rtl/sifive_mstatus_pkg.sv
// Shared constants, FSM/arbiter enums and the MPP WARL helper for the mstatus controller.
// Optional FS/SD support is enabled with SIFIVE_MSTATUS_FS_EN; see sifive_mstatus_ctrl.
package sifive_mstatus_pkg;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_LO = 11;
  localparam int FS_LO  = 13;
  localparam int MPRV   = 17;
  localparam int TW     = 21;
  localparam int SD     = 31;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_M = 2'b11;

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  typedef enum logic [1:0] {W_TRAP, W_MRET, W_CSR} winner_t;

  // Only U and M exist on this core, so only those encodings stick in MPP.
  function automatic logic mpp_legal(input logic [1:0] v);
    return (v == PRV_U) || (v == PRV_M);
  endfunction

endpackage

// File: rtl/sifive_mstatus_wfi_timer.sv
// WFI timeout: counts stalled U-mode WFI cycles while TW=1 and pulses wfi_illegal at WFI_TIMEOUT.
// Pulse is combinational in the matching cycle; no backpressure, the counter simply restarts.
module sifive_mstatus_wfi_timer
  import sifive_mstatus_pkg::*;
#(
  parameter int WFI_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wfi_req,
  input  logic       tw,
  input  logic [1:0] prv,
  output logic       wfi_illegal
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(WFI_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic             active;
  logic             hit;

  assign active      = wfi_req & tw & (prv != PRV_M);
  assign hit         = active & (cnt_q == TMO);
  assign wfi_illegal = hit & ~reset;

  always_ff @(posedge clock) begin
    if (reset || !active || hit) cnt_q <= '0;
    else                         cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/sifive_mstatus_ctrl.sv
// mstatus owner: trap/MRET/CSR-write arbiter (trap > mret > csr) feeding an IDLE/COMMIT FSM.
// Grant one cycle after request, fields update the cycle after; losers stay pending. FS via SIFIVE_MSTATUS_FS_EN.
module sifive_mstatus_ctrl
  import sifive_mstatus_pkg::*;
#(
  parameter int HAS_UMODE   = 1,
  parameter int WFI_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  prv,
  input  logic        trap_req,
  output logic        trap_gnt,
  input  logic        mret_req,
  output logic        mret_gnt,
  output logic [1:0]  mret_prv,
  input  logic        csr_wr_req,
  input  logic [31:0] csr_wr_data,
  output logic        csr_wr_gnt,
  input  logic        fp_dirty,
  input  logic        wfi_req,
  output logic        wfi_illegal,
  output logic [31:0] mstatus_rdata,
  output logic        mie,
  output logic        mpie,
  output logic        mprv,
  output logic        tw,
  output logic        sd,
  output logic [1:0]  mpp,
  output logic [1:0]  fs
);

  localparam bit UMODE = (HAS_UMODE != 0);

  state_t     state_q, state_d;
  winner_t    winner_q, winner_d;
  logic       mie_q, mpie_q, mprv_q, tw_q;
  logic [1:0] mpp_q;
  logic       in_commit;
  logic [1:0] wr_mpp;
  logic       unused_bits;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE: begin
        if (trap_req) begin
          winner_d = W_TRAP;
          state_d  = S_COMMIT;
        end else if (mret_req) begin
          winner_d = W_MRET;
          state_d  = S_COMMIT;
        end else if (csr_wr_req) begin
          winner_d = W_CSR;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      winner_q <= W_TRAP;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  // Reset during COMMIT suppresses the grant so the requester never sees a dropped update.
  assign in_commit  = (state_q == S_COMMIT) & ~reset;
  assign trap_gnt   = in_commit & (winner_q == W_TRAP);
  assign mret_gnt   = in_commit & (winner_q == W_MRET);
  assign csr_wr_gnt = in_commit & (winner_q == W_CSR);
  assign mret_prv   = mpp_q;

  assign wr_mpp = !UMODE                                   ? PRV_M :
                  mpp_legal(csr_wr_data[MPP_LO +: 2])      ? csr_wr_data[MPP_LO +: 2] :
                                                             mpp_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
      mpp_q  <= PRV_M;
      mprv_q <= 1'b0;
      tw_q   <= 1'b0;
    end else if (trap_gnt) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
      mpp_q  <= UMODE ? prv : PRV_M;
    end else if (mret_gnt) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
      mpp_q  <= UMODE ? PRV_U : PRV_M;
      if (mpp_q != PRV_M) mprv_q <= 1'b0;
    end else if (csr_wr_gnt) begin
      mie_q  <= csr_wr_data[MIE];
      mpie_q <= csr_wr_data[MPIE];
      mpp_q  <= wr_mpp;
      mprv_q <= UMODE & csr_wr_data[MPRV];
      tw_q   <= UMODE & csr_wr_data[TW];
    end
  end

`ifdef SIFIVE_MSTATUS_FS_EN
  logic [1:0] fs_q;

  // An FP write racing a CSR write must leave FS dirty.
  always_ff @(posedge clock) begin
    if (reset)           fs_q <= 2'b00;
    else if (fp_dirty)   fs_q <= 2'b11;
    else if (csr_wr_gnt) fs_q <= csr_wr_data[FS_LO +: 2];
  end

  assign fs = fs_q;
  assign sd = (fs_q == 2'b11);
`else
  assign fs = 2'b00;
  assign sd = 1'b0;
`endif

  assign unused_bits = ^{fp_dirty, csr_wr_data};

  assign mie  = mie_q;
  assign mpie = mpie_q;
  assign mpp  = mpp_q;
  assign mprv = mprv_q;
  assign tw   = tw_q;

  always_comb begin
    mstatus_rdata                = '0;
    mstatus_rdata[MIE]           = mie_q;
    mstatus_rdata[MPIE]          = mpie_q;
    mstatus_rdata[MPP_LO +: 2]   = mpp_q;
    mstatus_rdata[FS_LO +: 2]    = fs;
    mstatus_rdata[MPRV]          = mprv_q;
    mstatus_rdata[TW]            = tw_q;
    mstatus_rdata[SD]            = sd;
  end

  sifive_mstatus_wfi_timer #(
    .WFI_TIMEOUT(WFI_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wfi_timer (
    .clock      (clock),
    .reset      (reset),
    .wfi_req    (wfi_req),
    .tw         (tw_q),
    .prv        (prv),
    .wfi_illegal(wfi_illegal)
  );

endmodule

// File: tb/tb_sifive_mstatus_ctrl.sv
// Directed bench for sifive_mstatus_ctrl; FS expectations follow SIFIVE_MSTATUS_FS_EN.
module tb_sifive_mstatus_ctrl;

  logic        clock;
  logic        reset;
  logic [1:0]  prv;
  logic        trap_req, trap_gnt;
  logic        mret_req, mret_gnt;
  logic [1:0]  mret_prv;
  logic        csr_wr_req, csr_wr_gnt;
  logic [31:0] csr_wr_data;
  logic        fp_dirty;
  logic        wfi_req, wfi_illegal;
  logic [31:0] mstatus_rdata;
  logic        mie, mpie, mprv, tw, sd;
  logic [1:0]  mpp, fs;

  int n_cmp = 0;
  int n_err = 0;

  sifive_mstatus_ctrl #(.HAS_UMODE(1), .WFI_TIMEOUT(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .prv(prv),
    .trap_req(trap_req), .trap_gnt(trap_gnt),
    .mret_req(mret_req), .mret_gnt(mret_gnt), .mret_prv(mret_prv),
    .csr_wr_req(csr_wr_req), .csr_wr_data(csr_wr_data), .csr_wr_gnt(csr_wr_gnt),
    .fp_dirty(fp_dirty), .wfi_req(wfi_req), .wfi_illegal(wfi_illegal),
    .mstatus_rdata(mstatus_rdata),
    .mie(mie), .mpie(mpie), .mprv(mprv), .tw(tw), .sd(sd), .mpp(mpp), .fs(fs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // CSR write; returns at the start of the cycle where the new fields are visible.
  task automatic csr_write(input logic [31:0] d);
    csr_wr_req  = 1'b1;
    csr_wr_data = d;
    cyc();
    cyc();
    csr_wr_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; prv = 2'b11; trap_req = 0; mret_req = 0; csr_wr_req = 0;
    csr_wr_data = '0; fp_dirty = 0; wfi_req = 0;
    cyc(); cyc();
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0000_1800) begin n_err++; $display("FAIL reset_rdata got=%h exp=%h", mstatus_rdata, 32'h0000_1800); end
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt, wfi_illegal} !== 4'b0) begin n_err++; $display("FAIL reset_gnts got=%b exp=0000", {trap_gnt, mret_gnt, csr_wr_gnt, wfi_illegal}); end
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clock);
    n_cmp++; if ({mie, mpie, mpp, mprv, tw, fs, sd} !== 9'b0_0_11_0_0_00_0) begin n_err++; $display("FAIL reset_fields got=%b exp=%b", {mie, mpie, mpp, mprv, tw, fs, sd}, 9'b0_0_11_0_0_00_0); end
  endtask

  task automatic test_trap();
    csr_write(32'h0000_0008);
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0000_0008) begin n_err++; $display("FAIL trap_setup got=%h exp=%h", mstatus_rdata, 32'h0000_0008); end
    cyc();
    prv = 2'b00; trap_req = 1'b1;
    @(negedge clock);
    n_cmp++; if (trap_gnt !== 1'b0) begin n_err++; $display("FAIL trap_gnt_early got=%b exp=0", trap_gnt); end
    cyc();
    @(negedge clock);
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt} !== 3'b100) begin n_err++; $display("FAIL trap_gnt got=%b exp=100", {trap_gnt, mret_gnt, csr_wr_gnt}); end
    n_cmp++; if (mie !== 1'b1) begin n_err++; $display("FAIL trap_mie_during_commit got=%b exp=1", mie); end
    cyc();
    trap_req = 1'b0;
    @(negedge clock);
    n_cmp++; if ({mie, mpie, mpp} !== 4'b0_1_00) begin n_err++; $display("FAIL trap_fields got=%b exp=0100", {mie, mpie, mpp}); end
    n_cmp++; if (mstatus_rdata !== 32'h0000_0080) begin n_err++; $display("FAIL trap_rdata got=%h exp=%h", mstatus_rdata, 32'h0000_0080); end
    n_cmp++; if (trap_gnt !== 1'b0) begin n_err++; $display("FAIL trap_gnt_one_cycle got=%b exp=0", trap_gnt); end
  endtask

  task automatic test_priority();
    cyc();
    csr_write(32'h0000_0080);
    prv = 2'b11; trap_req = 1'b1; mret_req = 1'b1; csr_wr_req = 1'b1; csr_wr_data = 32'h0000_0008;
    cyc();
    @(negedge clock);
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt} !== 3'b100) begin n_err++; $display("FAIL prio_n1 got=%b exp=100", {trap_gnt, mret_gnt, csr_wr_gnt}); end
    cyc();
    trap_req = 1'b0;
    @(negedge clock);
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt} !== 3'b000) begin n_err++; $display("FAIL prio_n2 got=%b exp=000", {trap_gnt, mret_gnt, csr_wr_gnt}); end
    n_cmp++; if ({mie, mpie, mpp} !== 4'b0_0_11) begin n_err++; $display("FAIL prio_after_trap got=%b exp=0011", {mie, mpie, mpp}); end
    cyc();
    @(negedge clock);
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt} !== 3'b010) begin n_err++; $display("FAIL prio_n3 got=%b exp=010", {trap_gnt, mret_gnt, csr_wr_gnt}); end
    n_cmp++; if (mret_prv !== 2'b11) begin n_err++; $display("FAIL prio_mret_prv got=%b exp=11", mret_prv); end
    cyc();
    mret_req = 1'b0;
    @(negedge clock);
    n_cmp++; if ({mie, mpie, mpp} !== 4'b0_1_00) begin n_err++; $display("FAIL prio_after_mret got=%b exp=0100", {mie, mpie, mpp}); end
    cyc();
    @(negedge clock);
    n_cmp++; if (csr_wr_gnt !== 1'b1) begin n_err++; $display("FAIL prio_csr_last got=%b exp=1", csr_wr_gnt); end
    cyc();
    csr_wr_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0000_0008) begin n_err++; $display("FAIL prio_csr_rdata got=%h exp=%h", mstatus_rdata, 32'h0000_0008); end
  endtask

  task automatic test_csr_warl();
    cyc();
    csr_write(32'h0002_0808);
    @(negedge clock);
    n_cmp++; if ({mie, mpie, mpp, mprv} !== 5'b1_0_00_1) begin n_err++; $display("FAIL warl_fields got=%b exp=10001", {mie, mpie, mpp, mprv}); end
    n_cmp++; if (mstatus_rdata !== 32'h0002_0008) begin n_err++; $display("FAIL warl_rdata got=%h exp=%h", mstatus_rdata, 32'h0002_0008); end
    cyc();
    mret_req = 1'b1;
    cyc();
    @(negedge clock);
    n_cmp++; if ({mret_gnt, mret_prv} !== 3'b1_00) begin n_err++; $display("FAIL warl_mret_gnt got=%b exp=100", {mret_gnt, mret_prv}); end
    cyc();
    mret_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0000_0080) begin n_err++; $display("FAIL warl_mret_rdata got=%h exp=%h", mstatus_rdata, 32'h0000_0080); end
    cyc();
    csr_write(32'h0002_1000);
    @(negedge clock);
    n_cmp++; if (mpp !== 2'b00) begin n_err++; $display("FAIL warl_mpp10 got=%b exp=00", mpp); end
    cyc();
    csr_write(32'h0002_1800);
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0002_1800) begin n_err++; $display("FAIL warl_mpp11 got=%h exp=%h", mstatus_rdata, 32'h0002_1800); end
    cyc();
    mret_req = 1'b1;
    cyc();
    @(negedge clock);
    n_cmp++; if (mret_prv !== 2'b11) begin n_err++; $display("FAIL warl_mret_prv_m got=%b exp=11", mret_prv); end
    cyc();
    mret_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0002_0080) begin n_err++; $display("FAIL warl_mprv_kept got=%h exp=%h", mstatus_rdata, 32'h0002_0080); end
  endtask

  task automatic test_wfi();
    int pulses;
    cyc();
    csr_write(32'h0020_0000);
    @(negedge clock);
    n_cmp++; if ({tw, mprv, mpp} !== 4'b1_0_00) begin n_err++; $display("FAIL wfi_setup got=%b exp=1000", {tw, mprv, mpp}); end
    cyc();
    prv = 2'b00; wfi_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) cyc();
      @(negedge clock);
      n_cmp++; if (wfi_illegal !== (k == 17)) begin n_err++; $display("FAIL wfi_u_cycle%0d got=%b exp=%b", k, wfi_illegal, (k == 17)); end
    end
    // Dropping the request mid-count must restart the timeout.
    cyc(); wfi_req = 1'b0;
    cyc(); wfi_req = 1'b1;
    for (int k = 1; k <= 10; k++) cyc();
    wfi_req = 1'b0;
    cyc(); wfi_req = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) cyc();
      @(negedge clock);
      if (wfi_illegal) pulses = pulses + (k == 17 ? 1 : 100);
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL wfi_restart got=%0d exp=1", pulses); end
    cyc(); wfi_req = 1'b0;
    cyc(); prv = 2'b11; wfi_req = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      @(negedge clock);
      if (wfi_illegal) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL wfi_m_mode got=%0d exp=0", pulses); end
    wfi_req = 1'b0;
  endtask

  task automatic test_fs();
    logic [1:0] exp_fs;
    cyc();
    csr_write(32'h0000_2000);
`ifdef SIFIVE_MSTATUS_FS_EN
    exp_fs = 2'b01;
`else
    exp_fs = 2'b00;
`endif
    @(negedge clock);
    n_cmp++; if ({fs, sd} !== {exp_fs, 1'b0}) begin n_err++; $display("FAIL fs_csr got=%b exp=%b", {fs, sd}, {exp_fs, 1'b0}); end
    cyc();
    fp_dirty = 1'b1;
    cyc();
    fp_dirty = 1'b0;
`ifdef SIFIVE_MSTATUS_FS_EN
    exp_fs = 2'b11;
`else
    exp_fs = 2'b00;
`endif
    @(negedge clock);
    n_cmp++; if ({fs, sd} !== {exp_fs, exp_fs[0]}) begin n_err++; $display("FAIL fs_dirty got=%b exp=%b", {fs, sd}, {exp_fs, exp_fs[0]}); end
    n_cmp++; if (mstatus_rdata[31] !== exp_fs[0]) begin n_err++; $display("FAIL fs_sd_bit got=%b exp=%b", mstatus_rdata[31], exp_fs[0]); end
    cyc();
    csr_write(32'h0000_0000);
    @(negedge clock);
    n_cmp++; if (fs !== 2'b00) begin n_err++; $display("FAIL fs_clear got=%b exp=00", fs); end
    cyc();
    csr_wr_req = 1'b1; csr_wr_data = 32'h0000_2000;
    cyc();
    fp_dirty = 1'b1;
    cyc();
    fp_dirty = 1'b0; csr_wr_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (fs !== exp_fs) begin n_err++; $display("FAIL fs_race got=%b exp=%b", fs, exp_fs); end
  endtask

  task automatic test_reset_in_commit();
    cyc();
    csr_write(32'h0000_0008);
    cyc();
    prv = 2'b00; trap_req = 1'b1;
    cyc();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (trap_gnt !== 1'b0) begin n_err++; $display("FAIL rst_commit_gnt got=%b exp=0", trap_gnt); end
    cyc();
    reset = 1'b0; trap_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (mstatus_rdata !== 32'h0000_1800) begin n_err++; $display("FAIL rst_commit_rdata got=%h exp=%h", mstatus_rdata, 32'h0000_1800); end
    cyc();
    @(negedge clock);
    n_cmp++; if ({trap_gnt, mret_gnt, csr_wr_gnt} !== 3'b000) begin n_err++; $display("FAIL rst_commit_idle got=%b exp=000", {trap_gnt, mret_gnt, csr_wr_gnt}); end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_priority();
    test_csr_warl();
    test_wfi();
    test_fs();
    test_reset_in_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
